// File: rtl/stock_if.sv
// Operator-side bus of the stock controller: request inputs and display/status outputs.
interface stock_if;
   logic [1:0] mode;
   logic [1:0] prod_sel;
   logic [3:0] amount;
   logic       confirm;
   logic       cancel;
   logic [3:0] quant;
   logic [3:0] max_add;
   logic [7:0] sold_cnt;
   logic       seg_en;
   logic       busy;
   logic       ok;
   logic       err;

   modport master (
      output mode, prod_sel, amount, confirm, cancel,
      input  quant, max_add, sold_cnt, seg_en, busy, ok, err
   );

   modport slave (
      input  mode, prod_sel, amount, confirm, cancel,
      output quant, max_add, sold_cnt, seg_en, busy, ok, err
   );
endinterface

// File: rtl/stock_ctrl.sv
// Four-product stock keeper: validates sell/restock requests, updates stock and
// sales counters, and drives a registered display view of the selected product.
//
// state  | meaning
// IDLE   | waiting for confirm
// CHECK  | request latched, range-checking amount against stock / free room
// UPDATE | writing stock and sales registers
// DONE   | ok pulse
// ERR    | err pulse
module stock_ctrl #(
   parameter int CAP  = 15,
   parameter int INIT = 10
) (
   input  logic   clk,
   input  logic   rst,
   stock_if.slave bus
);
   localparam logic [3:0] CAP4  = 4'(CAP);
   localparam logic [3:0] INIT4 = 4'(INIT);

   typedef enum logic [2:0] {IDLE, CHECK, UPDATE, DONE, ERR} state_t;

   state_t     state, state_nxt;
   logic [3:0] stock     [4];
   logic [7:0] sales     [4];
   logic [3:0] stock_nxt [4];
   logic [7:0] sales_nxt [4];
   logic [1:0] prod_l;
   logic [3:0] amt_l;
   logic       add_l;
   logic       latch_en;
   logic [3:0] cur_stock;
   logic [3:0] room;
   logic       reject;
   logic [8:0] sales_sum;

   assign cur_stock = stock[prod_l];
   assign room      = CAP4 - cur_stock;
   assign reject    = (amt_l == 4'd0) || (add_l ? (amt_l > room) : (amt_l > cur_stock));
   assign sales_sum = {1'b0, sales[prod_l]} + {5'd0, amt_l};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch_en  = 1'b0;
      case (state)
         IDLE: begin
            // cancel wins over a simultaneous confirm; mode 1x is not a transaction
            if (bus.confirm && !bus.cancel && !bus.mode[1]) begin
               latch_en  = 1'b1;
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (bus.cancel)  state_nxt = IDLE;
            else if (reject) state_nxt = ERR;
            else             state_nxt = UPDATE;
         end
         UPDATE:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_l <= 2'd0;
         amt_l  <= 4'd0;
         add_l  <= 1'b0;
      end else if (latch_en) begin
         prod_l <= bus.prod_sel;
         amt_l  <= bus.amount;
         add_l  <= bus.mode[0];
      end
   end

   // CHECK has already bounded amt_l, so the 4-bit stock arithmetic cannot wrap
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stock_nxt[i] = stock[i];
         sales_nxt[i] = sales[i];
         if (state == UPDATE && prod_l == 2'(i)) begin
            if (add_l) begin
               stock_nxt[i] = stock[i] + amt_l;
            end else begin
               stock_nxt[i] = stock[i] - amt_l;
               sales_nxt[i] = sales_sum[8] ? 8'hFF : sales_sum[7:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            stock[i] <= INIT4;
            sales[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            stock[i] <= stock_nxt[i];
            sales[i] <= sales_nxt[i];
         end
      end
   end

   // display reads the next-state values so an update shows the cycle after UPDATE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.quant    <= INIT4;
         bus.max_add  <= CAP4 - INIT4;
         bus.sold_cnt <= 8'd0;
         bus.seg_en   <= 1'b0;
      end else begin
         bus.quant    <= stock_nxt[bus.prod_sel];
         bus.max_add  <= CAP4 - stock_nxt[bus.prod_sel];
         bus.sold_cnt <= sales_nxt[bus.prod_sel];
         bus.seg_en   <= (bus.mode != 2'b11);
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.ok   = (state == DONE);
   assign bus.err  = (state == ERR);
endmodule

// File: tb/tb_stock_ctrl.sv
// Bench for stock_ctrl: directed transactions push expected ok/err pulses (kind and
// cycle) into a queue that an independent monitor pops as pulses appear.
module tb_stock_ctrl;
   logic clk;
   logic rst;
   int   cyc;
   int   compared;
   int   mismatched;

   typedef struct packed {
      logic   is_ok;
      int     at_cyc;
   } exp_t;

   exp_t exp_q [$];

   stock_if bus ();

   stock_ctrl #(.CAP(15), .INIT(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every ok/err pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst && (bus.ok || bus.err)) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_pulse: got ok=%0d err=%0d, expected none (cycle %0d)",
                     bus.ok, bus.err, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.ok == bus.err || bus.ok != e.is_ok || cyc != e.at_cyc) begin
               mismatched++;
               $display("FAIL pulse: got ok=%0d err=%0d at cycle %0d, expected %s at cycle %0d",
                        bus.ok, bus.err, cyc, e.is_ok ? "ok" : "err", e.at_cyc);
            end
         end
      end
   end

   // exp: 0 = err expected, 1 = ok expected, 2 = no pulse expected
   task automatic start(input logic [1:0] m, input logic [1:0] p, input logic [3:0] a,
                        input int exp);
      exp_t e;
      @(negedge clk);
      bus.mode     = m;
      bus.prod_sel = p;
      bus.amount   = a;
      bus.confirm  = 1'b1;
      if (exp != 2) begin
         e.is_ok  = (exp == 1);
         e.at_cyc = cyc + ((exp == 1) ? 3 : 2);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
      if (bus.busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic txn(input logic [1:0] m, input logic [1:0] p, input logic [3:0] a,
                      input int exp);
      start(m, p, a, exp);
      @(negedge clk);
      bus.confirm = 1'b0;
      wait_idle();
      @(negedge clk);
   endtask

   task automatic disp(input logic [1:0] p, input int q, input int mx, input int s);
      @(negedge clk);
      bus.prod_sel = p;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("quant_p%0d", p), int'(bus.quant), q);
      chk($sformatf("max_add_p%0d", p), int'(bus.max_add), mx);
      chk($sformatf("sold_cnt_p%0d", p), int'(bus.sold_cnt), s);
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst          = 1'b0;
      bus.mode     = 2'b00;
      bus.prod_sel = 2'd0;
      bus.amount   = 4'd0;
      bus.confirm  = 1'b0;
      bus.cancel   = 1'b0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_quant", int'(bus.quant), 10);
      chk("rst_max_add", int'(bus.max_add), 5);
      chk("rst_sold_cnt", int'(bus.sold_cnt), 0);
      chk("rst_seg_en", int'(bus.seg_en), 0);
      chk("rst_busy", int'(bus.busy), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("seg_en_after_rst", int'(bus.seg_en), 1);

      // sell 3 on product 1 with busy window check
      start(2'b00, 2'd1, 4'd3, 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.confirm = 1'b0;
         chk($sformatf("busy_n+%0d", k), int'(bus.busy), (k <= 3) ? 1 : 0);
      end
      disp(2'd1, 7, 8, 3);

      // product 2 boundaries
      txn(2'b00, 2'd2, 4'd11, 0);
      txn(2'b00, 2'd2, 4'd0, 0);
      disp(2'd2, 10, 5, 0);
      txn(2'b01, 2'd2, 4'd6, 0);
      txn(2'b01, 2'd2, 4'd0, 0);
      txn(2'b01, 2'd2, 4'd5, 1);
      disp(2'd2, 15, 0, 0);
      txn(2'b00, 2'd2, 4'd10, 1);
      disp(2'd2, 5, 10, 10);

      // cancel during CHECK
      start(2'b00, 2'd0, 4'd2, 2);
      @(negedge clk);
      bus.confirm = 1'b0;
      bus.cancel  = 1'b1;
      @(negedge clk);
      bus.cancel  = 1'b0;
      wait_idle();
      disp(2'd0, 10, 5, 0);

      // confirm and cancel together in IDLE
      @(negedge clk);
      bus.confirm = 1'b1;
      bus.cancel  = 1'b1;
      @(negedge clk);
      bus.confirm = 1'b0;
      bus.cancel  = 1'b0;
      chk("busy_confirm_cancel", int'(bus.busy), 0);

      // confirm held for two cycles: second one dropped
      start(2'b00, 2'd0, 4'd1, 1);
      @(negedge clk);
      @(negedge clk);
      bus.confirm = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      disp(2'd0, 9, 6, 1);

      // reset during UPDATE discards the transaction
      start(2'b00, 2'd0, 4'd2, 2);
      @(negedge clk);
      bus.confirm = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("busy_in_rst", int'(bus.busy), 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      disp(2'd0, 10, 5, 0);
      disp(2'd1, 10, 5, 0);

      // latched request unaffected by prod_sel/mode changes after confirm
      start(2'b00, 2'd0, 4'd4, 1);
      @(negedge clk);
      bus.confirm  = 1'b0;
      bus.prod_sel = 2'd1;
      bus.mode     = 2'b01;
      wait_idle();
      bus.mode = 2'b00;
      disp(2'd1, 10, 5, 0);
      disp(2'd0, 6, 9, 4);

      // drive product 3 sales to saturation
      for (int k = 0; k < 25; k++) begin
         txn(2'b00, 2'd3, 4'd10, 1);
         txn(2'b01, 2'd3, 4'd10, 1);
      end
      disp(2'd3, 10, 5, 250);
      txn(2'b00, 2'd3, 4'd10, 1);
      disp(2'd3, 0, 15, 255);
      txn(2'b00, 2'd3, 4'd1, 0);
      txn(2'b01, 2'd3, 4'd15, 1);
      txn(2'b01, 2'd3, 4'd1, 0);
      txn(2'b00, 2'd3, 4'd15, 1);
      disp(2'd3, 0, 15, 255);

      // mode 10 and 11: confirm ignored; 11 blanks display
      @(negedge clk);
      bus.mode    = 2'b10;
      bus.amount  = 4'd1;
      bus.confirm = 1'b1;
      @(negedge clk);
      bus.confirm = 1'b0;
      chk("busy_mode10", int'(bus.busy), 0);
      chk("seg_en_mode10", int'(bus.seg_en), 1);
      bus.mode = 2'b11;
      @(negedge clk);
      bus.confirm = 1'b1;
      @(negedge clk);
      bus.confirm = 1'b0;
      chk("seg_en_mode11", int'(bus.seg_en), 0);
      chk("busy_mode11", int'(bus.busy), 0);
      bus.mode = 2'b00;
      repeat (4) @(negedge clk);
      chk("seg_en_restored", int'(bus.seg_en), 1);
      disp(2'd3, 0, 15, 255);

      chk("pending_expectations", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/stock_ctrl.md
STOCK_CTRL -- requirements
Module: stock_ctrl

Interface
REQ-001 Parameter CAP, default 15, maximum stock per product (1..15).
REQ-002 Parameter INIT, default 10, stock loaded into every product at reset (0..CAP).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mode  input  2  operation: 00 sell, 01 add (restock), 10 check sales, 11 display off.
REQ-006 prod_sel  input  2  product index 0..3.
REQ-007 amount  input  4  requested units for sell/add.
REQ-008 confirm  input  1  single-cycle pulse that starts a transaction.
REQ-009 cancel  input  1  single-cycle pulse that aborts a pending transaction.
REQ-010 quant  output  4  stock of the displayed product, to the display stage.
REQ-011 max_add  output  4  CAP minus quant, to the display stage.
REQ-012 sold_cnt  output  8  cumulative units sold of the displayed product.
REQ-013 seg_en  output  1  display enable.
REQ-014 busy  output  1  high while the FSM is not in IDLE.
REQ-015 ok  output  1  one-cycle pulse: transaction committed.
REQ-016 err  output  1  one-cycle pulse: transaction rejected.

Function
REQ-017 Storage: four 4-bit stock registers and four 8-bit sales registers, one of each per product.
REQ-018 FSM states: IDLE, CHECK, UPDATE, DONE, ERR.
REQ-019 IDLE: on confirm=1 and cancel=0, latch prod_sel, amount and mode[0], then go to CHECK; otherwise stay in IDLE.
REQ-020 In IDLE, confirm is ignored when mode is 10 or 11.
REQ-021 In IDLE, cancel has priority over a simultaneous confirm, and nothing is latched.
REQ-022 CHECK, sell: go to ERR if amount is 0 or amount > stock[prod]; otherwise go to UPDATE.
REQ-023 CHECK, add: go to ERR if amount is 0 or amount > CAP - stock[prod]; otherwise go to UPDATE.
REQ-024 CHECK, cancel=1: go to IDLE with no update and no ok/err pulse; cancel in any other non-IDLE state is ignored.
REQ-025 UPDATE, sell: stock -= amount; sales += amount, saturating at 255. Then go to DONE.
REQ-026 UPDATE, add: stock += amount; sales unchanged. Then go to DONE.
REQ-027 DONE: ok=1 for that single cycle, then go to IDLE.
REQ-028 ERR: err=1 for that single cycle, then go to IDLE.
REQ-029 Timing, for confirm sampled at edge N:
- err is high in cycle N+2;
- ok is high in cycle N+3;
- busy is high from N+1 until the FSM returns to IDLE.
REQ-030 Confirm pulses arriving while busy=1 are dropped, not queued.
REQ-031 Stock values never go below 0 or above CAP; 4-bit arithmetic never wraps.
REQ-032 quant, max_add and sold_cnt are registered and reflect the current prod_sel with 1-cycle latency.
REQ-033 An update to the displayed product is visible on quant, max_add and sold_cnt one cycle after UPDATE.
REQ-034 seg_en is registered: 0 when mode=11, 1 otherwise.
REQ-035 prod_sel and mode changes after confirm do not affect the latched transaction.

Reset
REQ-036 rst=0 asynchronously forces:
- every stock register to INIT and every sales register to 0;
- state to IDLE;
- quant=INIT, max_add=CAP-INIT, sold_cnt=0, seg_en=0, busy=0, ok=0, err=0.
REQ-037 Reset asserted mid-transaction discards it: no ok/err pulse and no partial update.

Verification
REQ-038 Reset, prod_sel=0, mode=00 -> quant=10, max_add=5, sold_cnt=0; seg_en=1 one cycle after release.
REQ-039 Sell amount=3 on product 1, confirm at N -> ok at N+3; quant 10->7, max_add 5->8, sold_cnt=3; busy high for N+1..N+3.
REQ-040 Sell amount=11 on product 2 (stock 10) -> err at N+2; stock stays 10; add amount=6 (room 5) -> err; add amount=5 -> ok, quant=15, max_add=0.
REQ-041 Confirm then cancel in the next cycle -> no ok/err, stock unchanged; confirm with cancel simultaneous in IDLE -> busy stays 0.
REQ-042 Second confirm at N+1 during a transaction -> dropped, exactly one ok; reset pulse at N+2 of a sell -> stock=10, no ok.
REQ-043 Repeated sells and restocks on product 3 until sales reach 255 -> sold_cnt holds 255, no wrap; mode=11 -> seg_en=0 and confirm ignored.
